// File: rtl/psc_trigger_tx_scheduler.sv
// PSC trigger transmit scheduler: chooses which frame (trigger, command or
// keepalive) goes out next on a slot-timed serial link, and steps the ROM
// byte address / load strobe for the encoder one symbol slot at a time.
module psc_trigger_tx_scheduler #(
  parameter int TICK_DIV        = 50,
  parameter int FRAME_LEN       = 8,
  parameter int GAP_SLOTS       = 2,
  parameter int KEEPALIVE_SLOTS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evr_trigger,
  input  logic       cmd_req,
  output logic       cmd_ack,
  output logic [3:0] tx_counter,
  output logic [1:0] frame_type,
  output logic       is_trigger,
  output logic       load_register,
  output logic       tx_busy,
  output logic [7:0] overrun_count,
  output logic [1:0] fsm_state
);

  localparam int SLOT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] FT_KEEPALIVE = 2'b00;
  localparam logic [1:0] FT_TRIGGER   = 2'b01;
  localparam logic [1:0] FT_COMMAND   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              sync1_q, sync2_q, sync3_q;
  logic              trig_pend_q, trig_pend_d;
  logic              cmd_req_q;
  logic [15:0]       ka_cnt_q, ka_cnt_d;
  logic              ka_due_q, ka_due_d;
  logic [3:0]        gap_q, gap_d;
  logic [3:0]        tx_counter_q, tx_counter_d;
  logic [1:0]        frame_type_q, frame_type_d;
  logic              is_trigger_q, is_trigger_d;
  logic              load_q, load_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [7:0]        ovr_q, ovr_d;

  logic tick;
  logic trig_edge;
  logic cmd_pend;

  assign tick      = (slot_q == SLOT_W'(TICK_DIV - 1));
  assign trig_edge = sync2_q & ~sync3_q;
  // Command request/acknowledge: cmd_req is a level the host holds until it
  // sees the one-cycle cmd_ack; a request must be seen on two consecutive
  // cycles, so one raised in a tick cycle waits for the next tick, and a
  // request dropped before its tick is simply never granted.
  assign cmd_pend  = cmd_req_q & cmd_req;

  // Synchroniser chain for the asynchronous trigger plus an edge-history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      cmd_req_q <= 1'b0;
    end else begin
      sync1_q   <= evr_trigger;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      cmd_req_q <= cmd_req;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      trig_pend_q  <= 1'b0;
      ka_cnt_q     <= '0;
      ka_due_q     <= 1'b0;
      gap_q        <= '0;
      tx_counter_q <= '0;
      frame_type_q <= '0;
      is_trigger_q <= 1'b0;
      load_q       <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      trig_pend_q  <= trig_pend_d;
      ka_cnt_q     <= ka_cnt_d;
      ka_due_q     <= ka_due_d;
      gap_q        <= gap_d;
      tx_counter_q <= tx_counter_d;
      frame_type_q <= frame_type_d;
      is_trigger_q <= is_trigger_d;
      load_q       <= load_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
    end
  end

  // Slot timing, frame selection, byte stepping, keepalive and overrun logic.
  always_comb begin
    state_d      = state_q;
    slot_d       = tick ? '0 : slot_q + 1'b1;
    trig_pend_d  = trig_pend_q;
    ka_cnt_d     = ka_cnt_q;
    ka_due_d     = ka_due_q;
    gap_d        = gap_q;
    tx_counter_d = tx_counter_q;
    frame_type_d = frame_type_q;
    is_trigger_d = is_trigger_q;
    load_d       = 1'b0;
    ack_d        = 1'b0;
    busy_d       = busy_q;
    ovr_d        = ovr_q;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (trig_pend_q || cmd_pend || ka_due_q) begin
            // Selecting tick: first byte goes out now, frame type frozen.
            state_d      = SEND;
            tx_counter_d = '0;
            gap_d        = '0;
            load_d       = 1'b1;
            busy_d       = 1'b1;
            ka_cnt_d     = '0;
            ka_due_d     = 1'b0;
            if (trig_pend_q) begin
              frame_type_d = FT_TRIGGER;
              trig_pend_d  = 1'b0;
            end else if (cmd_pend) begin
              frame_type_d = FT_COMMAND;
              ack_d        = 1'b1;
            end else begin
              frame_type_d = FT_KEEPALIVE;
            end
            is_trigger_d = (frame_type_d == FT_TRIGGER);
          end else begin
            // Idle slot: count toward the keepalive, holding at the limit.
            if (ka_cnt_q != 16'(KEEPALIVE_SLOTS)) ka_cnt_d = ka_cnt_q + 16'd1;
            if (ka_cnt_q == 16'(KEEPALIVE_SLOTS - 1)) ka_due_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tick) begin
          // The tick closing the last byte's slot starts the gap.
          if (tx_counter_q == 4'(FRAME_LEN - 1)) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            tx_counter_d = tx_counter_q + 4'd1;
            load_d       = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == 4'(GAP_SLOTS - 1)) begin
            state_d      = IDLE;
            tx_counter_d = '0;
            busy_d       = 1'b0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A trigger that cannot be queued is counted rather than stacked.
    if (trig_edge) begin
      if (trig_pend_q || (state_q == SEND && frame_type_q == FT_TRIGGER)) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end else begin
        trig_pend_d = 1'b1;
      end
    end
  end

  assign cmd_ack       = ack_q;
  assign tx_counter    = tx_counter_q;
  assign frame_type    = frame_type_q;
  assign is_trigger    = is_trigger_q;
  assign load_register = load_q;
  assign tx_busy       = busy_q;
  assign overrun_count = ovr_q;
  assign fsm_state     = state_q;

endmodule
